operand_packetizer: RTL

- Transmit side of the 48-bit operand word link into the calc operand collector.
- Accepts one transaction: two signed 80-bit operands, a 3-bit app code and a sel bit.
- Serializes it into four 48-bit words: A-hi, A-lo, B-hi, B-lo.
- Drives the all-zero idle word on every cycle it is not sending, because the collector samples the bus every clk and has no valid input.

---
 rtl/calc_link_pkg.sv | 47 ++++
 rtl/calc_word_fmt.sv | 25 ++
 rtl/operand_packetizer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/calc_link_pkg.sv
// Shared definitions for the 48-bit calc operand word link (packetizer and collector).
// Latency: none (types, constants and a pure function only).
// Backpressure: none; the link itself has no flow control.
package calc_link_pkg;

  // Legal application codes; 3'b000 is reserved as the collector's clear code.
  localparam logic [2:0] APP_ADD = 3'b001;
  localparam logic [2:0] APP_SUB = 3'b010;
  localparam logic [2:0] APP_MUL = 3'b011;

  localparam logic [2:0] PKT_HI = 3'b000;
  localparam logic [2:0] PKT_LI = 3'b001;

  localparam logic OPERAND_A = 1'b0;
  localparam logic OPERAND_B = 1'b1;

  localparam logic [47:0] IDLE_WORD = 48'h0;

  // Word field positions.
  localparam int APP_MSB = 47;
  localparam int APP_LSB = 45;
  localparam int AB_BIT  = 44;
  localparam int SEL_BIT = 43;
  localparam int PKT_MSB = 42;
  localparam int PKT_LSB = 40;
  localparam int PAY_MSB = 39;
  localparam int PAY_LSB = 0;

  typedef enum logic [1:0] {
    PK_IDLE = 2'd0,
    PK_SEND = 2'd1,
    PK_GAP  = 2'd2
  } pk_state_t;

  // One captured transaction.
  typedef struct packed {
    logic [79:0] a;
    logic [79:0] b;
    logic [2:0]  app;
    logic        sel;
  } txn_t;

  function automatic logic app_legal(input logic [2:0] code);
    return (code == APP_ADD) || (code == APP_SUB) || (code == APP_MUL);
  endfunction

endpackage

// File: rtl/calc_word_fmt.sv
// Builds one 48-bit link word from its fields.
// Latency: purely combinational.
// Backpressure: none.
module calc_word_fmt
  import calc_link_pkg::*;
(
  input  logic [2:0]  app,
  input  logic        ab,
  input  logic        sel,
  input  logic [2:0]  packet,
  input  logic [39:0] payload,
  output logic [47:0] word
);

  // Place each field at its fixed bit position.
  always_comb begin
    word                   = IDLE_WORD;
    word[APP_MSB:APP_LSB]  = app;
    word[AB_BIT]           = ab;
    word[SEL_BIT]          = sel;
    word[PKT_MSB:PKT_LSB]  = packet;
    word[PAY_MSB:PAY_LSB]  = payload;
  end

endmodule

// File: rtl/operand_packetizer.sv
// Serializes {A, B, app, sel} into A-hi, A-lo, B-hi, B-lo words; idle word 0 otherwise.
// Latency: handshake at edge T puts A-hi on dataout in the following cycle; all outputs registered.
// Backpressure: ready low while busy; OPERAND_PACKETIZER_SKID_EN adds a one-entry pending buffer.
module operand_packetizer
  import calc_link_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int IDLE_GAP    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] input_a,
  input  logic [79:0] input_b,
  input  logic [2:0]  app,
  input  logic        sel,
  input  logic        start,
  output logic        ready,
  output logic [47:0] dataout,
  output logic        dataout_valid,
  output logic        done,
  output logic        err
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("operand_packetizer: HOLD_CYCLES must be in 1..15");
  end
  if (IDLE_GAP < 1 || IDLE_GAP > 15) begin : g_bad_gap
    $error("operand_packetizer: IDLE_GAP must be in 1..15");
  end

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  pk_state_t   state_q, state_d;
  logic [1:0]  word_idx_q, word_idx_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  gap_q, gap_d;
  txn_t        cur_q, cur_d;
  txn_t        in_txn, launch_txn;
  logic        hs, hs_ok, gap_last, launch;
  logic        ready_q, ready_d;
  logic [47:0] dataout_q;
  logic        valid_q, done_q, err_q;
  logic        fmt_ab;
  logic [2:0]  fmt_pkt;
  logic [79:0] fmt_op;
  logic [39:0] fmt_payload;
  logic [47:0] fmt_word;
`ifdef OPERAND_PACKETIZER_SKID_EN
  txn_t        pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
`endif

  // Next-state, counters, capture and pending-buffer control.
  always_comb begin
    hs         = start && ready_q;
    hs_ok      = hs && app_legal(app);
    gap_last   = (state_q == PK_GAP) && (gap_q == GAP_LAST);
    in_txn     = '{a: input_a, b: input_b, app: app, sel: sel};
    state_d    = state_q;
    word_idx_d = word_idx_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    cur_d      = cur_q;
`ifdef OPERAND_PACKETIZER_SKID_EN
    // A buffered transaction has priority; ready is low whenever it is full.
    launch      = ((state_q == PK_IDLE) || gap_last) && (pend_full_q || hs_ok);
    launch_txn  = pend_full_q ? pend_q : in_txn;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (launch && pend_full_q) begin
      pend_full_d = 1'b0;
    end
    if (hs_ok && !launch) begin
      pend_d      = in_txn;
      pend_full_d = 1'b1;
    end
`else
    launch     = ((state_q == PK_IDLE) || gap_last) && hs_ok;
    launch_txn = in_txn;
`endif
    if (launch) begin
      state_d    = PK_SEND;
      word_idx_d = 2'd0;
      hold_d     = 4'd0;
      gap_d      = 4'd0;
      cur_d      = launch_txn;
    end else begin
      case (state_q)
        PK_SEND: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = 4'd0;
            if (word_idx_q == 2'd3) begin
              state_d = PK_GAP;
              gap_d   = 4'd0;
            end else begin
              word_idx_d = word_idx_q + 2'd1;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        PK_GAP: begin
          if (gap_last) begin
            state_d = PK_IDLE;
            gap_d   = 4'd0;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default: begin
          state_d = PK_IDLE;
        end
      endcase
    end
  end

  // Select the fields of the word that will be on the bus next cycle.
  always_comb begin
    fmt_ab      = word_idx_d[1] ? OPERAND_B : OPERAND_A;
    fmt_pkt     = word_idx_d[0] ? PKT_LI : PKT_HI;
    fmt_op      = word_idx_d[1] ? cur_d.b : cur_d.a;
    fmt_payload = word_idx_d[0] ? fmt_op[39:0] : fmt_op[79:40];
  end

  calc_word_fmt u_fmt (
    .app     (cur_d.app),
    .ab      (fmt_ab),
    .sel     (cur_d.sel),
    .packet  (fmt_pkt),
    .payload (fmt_payload),
    .word    (fmt_word)
  );

  // Ready rises during the last gap cycle so a new A-hi directly follows IDLE_GAP idle words.
  always_comb begin
`ifdef OPERAND_PACKETIZER_SKID_EN
    ready_d = !pend_full_d;
`else
    ready_d = (state_d == PK_IDLE) || ((state_d == PK_GAP) && (gap_d == GAP_LAST));
`endif
  end

  // State, counters, holding registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PK_IDLE;
      word_idx_q <= 2'd0;
      hold_q     <= 4'd0;
      gap_q      <= 4'd0;
      cur_q      <= '0;
      ready_q    <= 1'b1;
      dataout_q  <= IDLE_WORD;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      cur_q      <= cur_d;
      ready_q    <= ready_d;
      dataout_q  <= (state_d == PK_SEND) ? fmt_word : IDLE_WORD;
      valid_q    <= (state_d == PK_SEND);
      done_q     <= (state_d == PK_SEND) && (word_idx_d == 2'd3) && (hold_d == HOLD_LAST);
      err_q      <= hs && !app_legal(app);
    end
  end

`ifdef OPERAND_PACKETIZER_SKID_EN
  // One-entry pending buffer for a transaction accepted while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end
`endif

  assign ready         = ready_q;
  assign dataout       = dataout_q;
  assign dataout_valid = valid_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
